// File: rtl/nibble_serial_adder.sv
// Digit-serial WIDTH-bit adder: one DIGIT_W-bit ripple slice per clock,
// carry chained between slices through a register, valid/ready on both sides.
module nibble_serial_adder #(
   parameter int WIDTH   = 16,
   parameter int DIGIT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int N  = WIDTH / DIGIT_W;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   int                 sh;
   logic [WIDTH-1:0]   a_sh, b_sh;
   logic [DIGIT_W-1:0] a_dig, b_dig, s_dig;
   logic [DIGIT_W:0]   c_chain;
   logic [WIDTH-1:0]   dmask;

   // One DIGIT_W-bit ripple-carry slice, selected by idx
   always_comb begin
      sh    = int'(idx_q) * DIGIT_W;
      a_sh  = a_q >> sh;
      b_sh  = b_q >> sh;
      a_dig = a_sh[DIGIT_W-1:0];
      b_dig = b_sh[DIGIT_W-1:0];
      s_dig = '0;
      c_chain    = '0;
      c_chain[0] = carry_q;
      for (int i = 0; i < DIGIT_W; i++) begin
         s_dig[i]     = a_dig[i] ^ b_dig[i] ^ c_chain[i];
         c_chain[i+1] = (a_dig[i] & b_dig[i])
                      | (c_chain[i] & (a_dig[i] ^ b_dig[i]));
      end
      dmask = WIDTH'({DIGIT_W{1'b1}}) << sh;
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d   = (sum_q & ~dmask) | (WIDTH'(s_dig) << sh);
            carry_d = c_chain[DIGIT_W];
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST) begin
               cout_d  = c_chain[DIGIT_W];
               // top slice's carry into its MSB is the carry into bit WIDTH-1
               ovf_d   = c_chain[DIGIT_W] ^ c_chain[DIGIT_W-1];
               idx_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed vector table, hold/reset
// sequences, and random back-to-back traffic against an arithmetic model.
module tb_nibble_serial_adder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        cin = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;
   logic        busy;

   int checks = 0;
   int errors = 0;

   nibble_serial_adder #(.WIDTH(16), .DIGIT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                  input logic c);
      res_t r;
      int   t;
      int   sx, sy, ss;
      t      = int'(x) + int'(y) + int'(c);
      r.sum  = t[15:0];
      r.cout = t[16];
      sx = int'(signed'(x));
      sy = int'(signed'(y));
      ss = sx + sy + int'(c);
      r.ovf  = (ss > 32767) || (ss < -32768);
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one operand set; return cycles from the accept edge to out_valid.
   task automatic launch(input logic [15:0] x, input logic [15:0] y,
                         input logic c, output int lat);
      int w = 0;
      while (!in_ready && w < 20) begin step(); w++; end
      chk("in_ready_before_op", {31'd0, in_ready}, 32'd1);
      a = x; b = y; cin = c; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin step(); lat++; end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("in_ready_after_release", {31'd0, in_ready}, 32'd1);
   endtask

   vec_t vecs[6];
   res_t exp_q[$];

   initial begin
      int   lat;
      res_t r;
      logic [15:0] held;
      int   cyc, last_out, nres, pend;

      vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};

      #12;
      chk("rst_sum", {16'd0, sum}, 32'd0);
      chk("rst_flags", {28'd0, cout, ovf, out_valid, busy}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;
      step();

      foreach (vecs[i]) begin
         launch(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
         chk("vec_latency", lat, 32'd4);
         chk("vec_sum", {16'd0, sum}, {16'd0, vecs[i].sum});
         chk("vec_cout", {31'd0, cout}, {31'd0, vecs[i].cout});
         chk("vec_ovf", {31'd0, ovf}, {31'd0, vecs[i].ovf});
         chk("vec_ready_valid", {30'd0, in_ready, busy}, 32'd1);
         release_result();
      end

      // Stall: result held, new offers ignored
      launch(16'h1111, 16'h2222, 1'b0, lat);
      chk("stall_latency", lat, 32'd4);
      held = sum;
      chk("stall_sum", {16'd0, held}, 32'h3333);
      a = 16'hABCD; b = 16'h1234; in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("stall_valid", {30'd0, out_valid, in_ready}, 32'd2);
         chk("stall_hold", {16'd0, sum}, {16'd0, held});
      end
      in_valid = 1'b0;
      release_result();

      // Async reset while slice 2 is next
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_sum", {16'd0, sum}, 32'd0);
      chk("midrst_flags", {28'd0, cout, ovf, out_valid, busy}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      #3 rst_n = 1'b1;
      launch(16'h000F, 16'h0001, 1'b0, lat);
      chk("postrst_latency", lat, 32'd4);
      chk("postrst_sum", {16'd0, sum}, 32'h0010);
      chk("postrst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
      release_result();

      // Back-to-back random traffic
      out_ready = 1'b1;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      in_valid = 1'b1;
      cyc = 0; last_out = -1; nres = 0; pend = 0;
      while (nres < 1000 && cyc < 7000) begin
         if (pend != 0) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
         end
         if (in_ready && out_valid) chk("ready_and_valid", 32'd1, 32'd0);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("rnd_unexpected", 32'd1, 32'd0);
            end else begin
               r = exp_q.pop_front();
               chk("rnd_result", {15'd0, cout, sum}, {15'd0, r.cout, r.sum});
               chk("rnd_ovf", {31'd0, ovf}, {31'd0, r.ovf});
            end
            if (last_out >= 0) chk("rnd_spacing", cyc - last_out, 32'd6);
            last_out = cyc;
            nres++;
         end
         pend = 0;
         if (in_ready) begin
            exp_q.push_back(model(a, b, cin));
            pend = 1;
         end
         step();
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("rnd_count", nres, 32'd1000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
